// File: rtl/display_scheduler_if.sv
// Display scheduler bus: request/value inputs from the two clients, grant and indicator drives out.
// Latency: n/a (wiring only).
// Backpressure: none; clients hold req until they see grant at a frame boundary.
interface display_scheduler_if;
  logic [1:0]  req;
  logic [15:0] val0;
  logic [15:0] val1;
  logic [1:0]  grant;
  logic [3:0]  digits;
  logic [7:0]  segments;
  logic        frame_done;

  // Application side: drives requests and values, observes grant and pins
  modport master (
    output req, val0, val1,
    input  grant, digits, segments, frame_done
  );

  // Scheduler side
  modport slave (
    input  req, val0, val1,
    output grant, digits, segments, frame_done
  );
endinterface

// File: rtl/display_scheduler.sv
// Two-client frame-granular arbiter and 4-digit multiplexed scan driver with blanking and zero suppression.
// Latency: request-to-grant 1..4*DIV cycles; value latched on the boundary edge and shown the following frame.
// Backpressure: none; req/val sampled only on frame-boundary edges, grant held for whole frames.
module display_scheduler #(
  parameter int DIV   = 13,
  parameter int BLANK = 2,
  parameter int HOLD  = 4
) (
  input logic               clk,
  input logic               rst_n,
  display_scheduler_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [1:0]    r_state;
  logic [HW-1:0] r_hold;
  logic          r_last;
  logic [15:0]   r_shadow;

  logic          w_boundary;
  logic          w_cur;
  logic          w_oth;
  logic          w_pref;
  logic [1:0]    w_state_nx;
  logic [HW-1:0] w_hold_nx;
  logic          w_next_owner;
  logic [3:0]    w_nib;
  logic [3:0]    w_zero;
  logic [3:0]    w_supp;
  logic          w_active;

  function automatic logic [1:0] own_state(input logic who);
    return who ? ST_OWN1 : ST_OWN0;
  endfunction

  // Active-low segment pattern; DP (bit 7) is always off, non-decimal nibbles show a dash
  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  assign w_boundary   = (r_cnt == CNT_LAST) && (r_idx == 2'd3);
  assign w_cur        = (r_state == ST_OWN1);
  assign w_oth        = ~w_cur;
  assign w_pref       = ~r_last;
  assign w_next_owner = (w_state_nx == ST_OWN1);

  // Arbitration decision, applied only on the frame-boundary edge
  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    case (r_state)
      ST_OWN0, ST_OWN1: begin
        if (bus.req[w_cur] && !bus.req[w_oth]) begin
          // Uncontested owner: keep counting frames, saturating at the limit
          if (r_hold != HOLD_LAST) w_hold_nx = r_hold + 1'b1;
        end else if (bus.req[w_cur] && bus.req[w_oth] && (r_hold != HOLD_LAST)) begin
          w_hold_nx = r_hold + 1'b1;
        end else if (bus.req[w_oth]) begin
          w_state_nx = own_state(w_oth);
          w_hold_nx  = '0;
        end else begin
          w_state_nx = ST_IDLE;
          w_hold_nx  = '0;
        end
      end
      default: begin
        w_hold_nx = '0;
        if (bus.req[w_pref])       w_state_nx = own_state(w_pref);
        else if (bus.req[~w_pref]) w_state_nx = own_state(~w_pref);
        else                       w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Slot counter and digit index; the scan always runs, granted or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Ownership, hold count, last owner and displayed value update once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_last   <= 1'b1;
      r_shadow <= 16'h0000;
    end else if (w_boundary) begin
      r_state <= w_state_nx;
      r_hold  <= w_hold_nx;
      if (w_state_nx != ST_IDLE) begin
        r_last   <= w_next_owner;
        r_shadow <= w_next_owner ? bus.val1 : bus.val0;
      end
    end
  end

  assign w_nib     = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_zero[0] = (r_shadow[3:0]   == 4'h0);
  assign w_zero[1] = (r_shadow[7:4]   == 4'h0);
  assign w_zero[2] = (r_shadow[11:8]  == 4'h0);
  assign w_zero[3] = (r_shadow[15:12] == 4'h0);
  // Digit i blanks only when it and every more significant nibble are zero; digit 0 always shows
  assign w_supp    = {w_zero[3],
                      w_zero[3] & w_zero[2],
                      w_zero[3] & w_zero[2] & w_zero[1],
                      1'b0};
  assign w_active  = (r_state != ST_IDLE) && (r_cnt >= BLANK_END);

  // Pin drive decoded from registers only: blank gap, idle, suppression, then the digit itself
  always_comb begin
    bus.digits   = 4'b0000;
    bus.segments = 8'hFF;
    if (w_active) begin
      bus.digits   = 4'b0001 << r_idx;
      bus.segments = w_supp[r_idx] ? 8'hFF : seg7(w_nib);
    end
  end

  assign bus.grant      = {r_state == ST_OWN1, r_state == ST_OWN0};
  assign bus.frame_done = w_boundary;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (DIV=13, BLANK=2, HOLD=4); frame = 52 cycles.
module tb_display_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ph = 0;

  display_scheduler_if bus();

  display_scheduler #(.DIV(13), .BLANK(2), .HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // One clock; inputs and samples happen at the falling edge, ph is the cycle position in the frame
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    ph = (ph + 1) % 52;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
  endtask

  // Walk one frame from ph 0, recording what each slot shows and counting scan irregularities
  task automatic scan_frame(input bit mid_en, input logic [15:0] mid_val,
                            output logic [31:0] segs, output logic [15:0] digs,
                            output logic [1:0] gnt, output int odd,
                            output int fd_ph, output int fd_cnt);
    odd = 0; fd_ph = -1; fd_cnt = 0; segs = '0; digs = '0;
    gnt = bus.grant;
    for (int k = 0; k < 52; k++) begin
      int slot;
      int cc;
      slot = ph / 13;
      cc   = ph % 13;
      if (bus.grant !== gnt) odd++;
      if (bus.frame_done === 1'b1) begin fd_cnt++; fd_ph = ph; end
      if (cc < 2) begin
        if (bus.digits !== 4'b0000 || bus.segments !== 8'hFF) odd++;
      end else if (cc == 2) begin
        segs[slot*8 +: 8] = bus.segments;
        digs[slot*4 +: 4] = bus.digits;
      end else if (bus.segments !== segs[slot*8 +: 8] || bus.digits !== digs[slot*4 +: 4]) begin
        odd++;
      end
      if (mid_en && ph == 20) bus.val0 = mid_val;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    logic [31:0] s; logic [15:0] d; logic [1:0] g; int odd, fp, fc;
    bus.req = 2'b00; bus.val0 = 16'h0000; bus.val1 = 16'h0000;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b expected 00", bus.grant); end
    n_cmp++; if (bus.digits !== 4'b0000) begin n_bad++; $display("FAIL reset_digits: got %b expected 0000", bus.digits); end
    n_cmp++; if (bus.segments !== 8'hFF) begin n_bad++; $display("FAIL reset_segments: got %h expected ff", bus.segments); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    rst_n = 1'b1;
    ph = 0;
    for (int f = 0; f < 3; f++) begin
      scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
      n_cmp++; if (g !== 2'b00) begin n_bad++; $display("FAIL idle_grant f%0d: got %b expected 00", f, g); end
      n_cmp++; if (s !== 32'hFFFFFFFF || d !== 16'h0000 || odd !== 0) begin n_bad++; $display("FAIL idle_dark f%0d: got segs %h digs %h odd %0d expected ffffffff 0000 0", f, s, d, odd); end
      n_cmp++; if (fc !== 1 || 52*f + fp !== 52*f + 51) begin n_bad++; $display("FAIL idle_frame_done f%0d: got cycle %0d count %0d expected cycle %0d count 1", f, 52*f + fp, fc, 52*f + 51); end
    end
  endtask

  task automatic test_grant_basic();
    logic [31:0] s; logic [15:0] d; logic [1:0] g; int odd, fp, fc;
    bus.req = 2'b01; bus.val0 = 16'h1234; bus.val1 = 16'h0042;
    scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
    n_cmp++; if (g !== 2'b00 || s !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL pre_grant: got grant %b segs %h expected 00 ffffffff", g, s); end
    scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
    n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL first_grant: got %b expected 01", g); end
    n_cmp++; if (s !== 32'hF9A4B099) begin n_bad++; $display("FAIL show_1234: got %h expected f9a4b099", s); end
    n_cmp++; if (d !== 16'h8421) begin n_bad++; $display("FAIL scan_digits: got %h expected 8421", d); end
    n_cmp++; if (odd !== 0) begin n_bad++; $display("FAIL blank_gap: got %0d irregular cycles expected 0", odd); end
    n_cmp++; if (fc !== 1 || fp !== 51) begin n_bad++; $display("FAIL granted_frame_done: got ph %0d count %0d expected 51 1", fp, fc); end
  endtask

  task automatic test_suppress();
    logic [31:0] s; logic [15:0] d; logic [1:0] g; int odd, fp, fc;
    logic [15:0] tv [4];
    logic [31:0] te [4];
    tv[0] = 16'h0007; te[0] = 32'hFFFFFFF8;
    tv[1] = 16'h0000; te[1] = 32'hFFFFFFC0;
    tv[2] = 16'h00A5; te[2] = 32'hFFFFBF92;
    tv[3] = 16'h0900; te[3] = 32'hFF90C0C0;
    for (int k = 0; k < 4; k++) begin
      bus.val0 = tv[k];
      scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
      scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
      n_cmp++; if (s !== te[k]) begin n_bad++; $display("FAIL suppress_%h: got %h expected %h", tv[k], s, te[k]); end
      n_cmp++; if (d !== 16'h8421 || odd !== 0) begin n_bad++; $display("FAIL suppress_digits_%h: got %h odd %0d expected 8421 0", tv[k], d, odd); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] s; logic [15:0] d; logic [1:0] g; int odd, fp, fc;
    logic [1:0] eg [13];
    for (int f = 1; f <= 12; f++) eg[f] = 2'b01;
    for (int f = 5; f <= 8; f++) eg[f] = 2'b10;
    eg[11] = 2'b10; eg[12] = 2'b10;
    apply_reset();
    bus.req = 2'b11; bus.val0 = 16'h1234; bus.val1 = 16'h0042;
    scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
    n_cmp++; if (g !== 2'b00) begin n_bad++; $display("FAIL hold_f0: got %b expected 00", g); end
    for (int f = 1; f <= 12; f++) begin
      if (f == 10) bus.req = 2'b10;
      scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
      n_cmp++; if (g !== eg[f] || odd !== 0) begin n_bad++; $display("FAIL hold_f%0d: got grant %b odd %0d expected %b 0", f, g, odd, eg[f]); end
      if (f == 1) begin
        n_cmp++; if (s !== 32'hF9A4B099) begin n_bad++; $display("FAIL hold_val0: got %h expected f9a4b099", s); end
      end
      if (f == 5) begin
        n_cmp++; if (s !== 32'hFFFF99A4) begin n_bad++; $display("FAIL hold_val1: got %h expected ffff99a4", s); end
      end
    end
  endtask

  task automatic test_mid_change();
    logic [31:0] s; logic [15:0] d; logic [1:0] g; int odd, fp, fc;
    apply_reset();
    bus.req = 2'b01; bus.val0 = 16'h1234;
    scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
    scan_frame(1'b1, 16'h5678, s, d, g, odd, fp, fc);
    n_cmp++; if (s !== 32'hF9A4B099 || odd !== 0) begin n_bad++; $display("FAIL mid_keep_1234: got %h odd %0d expected f9a4b099 0", s, odd); end
    scan_frame(1'b0, 16'h0, s, d, g, odd, fp, fc);
    n_cmp++; if (s !== 32'h9282F880) begin n_bad++; $display("FAIL next_5678: got %h expected 9282f880", s); end
  endtask

  task automatic test_reset_mid();
    int c;
    for (int k = 0; k < 20; k++) next_cycle();
    n_cmp++; if (bus.digits !== 4'b0010) begin n_bad++; $display("FAIL pre_reset_digits: got %b expected 0010", bus.digits); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL async_grant: got %b expected 00", bus.grant); end
    n_cmp++; if (bus.digits !== 4'b0000 || bus.segments !== 8'hFF) begin n_bad++; $display("FAIL async_pins: got %b %h expected 0000 ff", bus.digits, bus.segments); end
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
    c = 0;
    while (bus.frame_done !== 1'b1 && c < 300) begin
      next_cycle();
      c++;
    end
    n_cmp++; if (c !== 51) begin n_bad++; $display("FAIL restart_frame_done: got cycle %0d expected 51", c); end
  endtask

  initial begin
    test_reset();
    test_grant_basic();
    test_suppress();
    test_hold();
    test_mid_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-multiplexed scan controller and two-client arbiter for the 4-digit, 8-segment common-anode indicator. Grants the display to one of two requesters at frame granularity, latches the granted 16-bit BCD value once per frame, and sequences the digit scan. Each digit slot has a leading blanking gap against ghosting, and leading zeros are suppressed. Sits between application blocks (counters, clocks, measurement units) and the indicator pins.

## Interface
- `DIV`, 13: clock cycles per digit slot; must be ≥ 2.
- `BLANK`, 2: cycles at the start of each slot with all digits off; must be < `DIV`.
- `HOLD`, 4: maximum consecutive frames one requester keeps the grant while the other is requesting; must be ≥ 1.

- `clk`  in  1  single clock; everything samples on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  2  request lines; `req[i]` high means requester i wants the display.
- `val0`  in  16  BCD value of requester 0; `[3:0]` is digit 0 (least significant), `[15:12]` is digit 3.
- `val1`  in  16  BCD value of requester 1; same layout as `val0`.
- `grant`  out  2  grant to the requesters; one-hot or `00` (idle).
- `digits`  out  4  digit enables, active-high, one-hot or `0000`.
- `segments`  out  8  segment drives, active-low; bit 7 is DP (always 1), bits 6..0 are segments G..A.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Slot counter `cnt` counts 0..`DIV`-1 and wraps.
  - On wrap, digit index `idx` advances 0→1→2→3→0.
  - A frame is 4·`DIV` cycles.
  - Frame boundary: `cnt`=`DIV`-1 and `idx`=3. `frame_done`=1 on that cycle only.
- Blanking: while `cnt` < `BLANK`, `digits`=0000 and `segments`=FF.
- Otherwise:
  - `digits`=1<<`idx`.
  - `segments`=decode(shadow nibble `idx`), unless the digit is suppressed or the display is idle.
- Decode (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Nibbles A–F decode to BF (dash, segment G only).
- Leading-zero suppression:
  - Digit i (i=1..3) is suppressed when its nibble and every higher nibble are 0.
  - A suppressed digit has `segments`=FF; `digits` is still asserted, so the scan timing stays uniform.
  - Digit 0 is never suppressed.
- Idle: when `grant`=00, `digits`=0000 and `segments`=FF for the whole frame.
- Arbitration states: IDLE, OWN0, OWN1. A frame counter `hold` (0..`HOLD`-1) counts frames of the current ownership. All transitions occur only on the frame-boundary edge:
  - From IDLE:
    - grant the requester not equal to `last`, if it is requesting;
    - else grant the other one, if it is requesting;
    - else stay in IDLE.
  - From OWNi with `req[i]`=1 and `req[1-i]`=0: stay in OWNi; `hold` saturates.
  - From OWNi with `req[i]`=1, `req[1-i]`=1 and `hold` < `HOLD`-1: stay in OWNi; `hold`++.
  - From OWNi with `req[1-i]`=1 and (`hold`=`HOLD`-1 or `req[i]`=0): go to OWN(1-i); `hold`=0.
  - From OWNi with `req[i]`=0 and `req[1-i]`=0: go to IDLE.
  - `last` records the most recent owner.
- Value latch: on the same boundary edge, shadow ← `val` of the next-state owner. The displayed value therefore never changes mid-frame, and a new owner's value appears in the first frame it is granted.
- Dropping `req` mid-frame does not revoke the grant before the boundary.

## Timing
- Reset (asynchronous, immediate) sets:
  - `cnt`=0, `idx`=0, `hold`=0;
  - state IDLE, `grant`=00, `last`=1 (requester 0 wins the first tie);
  - shadow=0000;
  - outputs `digits`=0000, `segments`=FF, `frame_done`=0.
- Internal state is registered. `digits`, `segments` and `frame_done` are decoded combinationally from registers only; there are no combinational paths from the inputs.
- The first boundary after reset release is on cycle 4·`DIV`-1, counting from the first active edge as cycle 0.
- Request-to-grant latency: 1 to 4·`DIV` cycles. `grant` changes only on a boundary edge.
- `req` and `val` are sampled only on boundary edges; changes at any other time are ignored.
- Reset asserted mid-frame returns all outputs to their reset values within the same cycle. The scan restarts from digit 0.

## Test plan
- Reset, `req`=00 for 3 frames (`DIV`=13) → `digits`=0000 and `segments`=FF throughout; `frame_done` pulses on cycles 51, 103 and 155.
- `req`=01, `val0`=1234 → `grant`=01 from the first boundary. Next frame:
  - digit 0 → 99, digit 1 → B0, digit 2 → A4, digit 3 → F9;
  - in each 13-cycle slot, the first 2 cycles are blank.
- `val0`=0007 → digits 3, 2, 1 at FF and digit 0 at F8. `val0`=0000 → digits 3..1 at FF and digit 0 at C0. `val0`=00A5 → digit 1 at BF and digit 0 at 92.
- `req`=11 held, `HOLD`=4 → `grant` sequence per frame: 01 ×4, 10 ×4, 01 ×4. Dropping `req[0]` during an 01 phase → 10 at the next boundary.
- `val0` changes from 1234 to 5678 mid-frame → the current frame still shows 1234; 5678 is shown from the next frame.
- `rst_n` pulsed low at cycle 20 of a granted frame → `grant`=00, `digits`=0000 and `segments`=FF immediately. After release, the first `frame_done` is 51 cycles later.
